// File: rtl/debug_sequencer.sv
// Debug sequencer: command-driven run/step/halt control of a pipeline, plus a
// register-file dump that streams every register MSB-first as four bytes.
//
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   cmd_valid/cmd_data - incoming command byte; cmd_ready acknowledges it
//   prog_end           - level from pipeline, end of program reached
//   reg_data           - register-file debug read data (one cycle latency)
//   tx_valid/tx_data   - outgoing dump byte; tx_ready from the byte sink
//   stop_debug         - freezes pipeline registers when 1
//   debug_on           - blocks RF writes and selects the debug read port
//   debug_read_reg     - RF index being read during a dump
//   busy               - 1 in every state except HALT
module debug_sequencer #(
  parameter int unsigned NREGS    = 32,
  parameter logic [7:0]  CMD_RUN  = 8'h63,
  parameter logic [7:0]  CMD_STEP = 8'h73,
  parameter logic [7:0]  CMD_DUMP = 8'h64,
  parameter logic [7:0]  CMD_HALT = 8'h68
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  input  logic        prog_end,
  input  logic [31:0] reg_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        stop_debug,
  output logic        debug_on,
  output logic [4:0]  debug_read_reg,
  output logic        busy
);

  typedef enum logic [2:0] {
    StHalt,
    StRun,
    StStep,
    StDumpSel,
    StDumpLatch,
    StDumpTx
  } state_e;

  localparam logic [4:0] LastIdx = 5'(NREGS - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StHalt;
      idx_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    stop_debug     = 1'b1;
    debug_on       = 1'b0;
    cmd_ready      = 1'b0;
    tx_valid       = 1'b0;
    debug_read_reg = '0;

    unique case (state_q)
      StHalt: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_data == CMD_RUN) begin
            state_d = StRun;
          end else if (cmd_data == CMD_STEP) begin
            state_d = StStep;
          end else if (cmd_data == CMD_DUMP) begin
            state_d = StDumpSel;
            idx_d   = '0;
          end
          // any other byte is consumed and ignored
        end
      end
      StRun: begin
        stop_debug = 1'b0;
        cmd_ready  = 1'b1;
        if (prog_end || (cmd_valid && (cmd_data == CMD_HALT))) begin
          state_d = StHalt;
        end
      end
      StStep: begin
        // prog_end deliberately ignored: the step always runs one cycle
        stop_debug = 1'b0;
        state_d    = StHalt;
      end
      StDumpSel: begin
        debug_on       = 1'b1;
        debug_read_reg = idx_q;
        state_d        = StDumpLatch;
      end
      StDumpLatch: begin
        // reg_data reflects idx_q here, one cycle after SEL presented it
        debug_on       = 1'b1;
        debug_read_reg = idx_q;
        shift_d        = reg_data;
        cnt_d          = '0;
        state_d        = StDumpTx;
      end
      StDumpTx: begin
        debug_on       = 1'b1;
        debug_read_reg = idx_q;
        tx_valid       = 1'b1;
        if (tx_ready) begin
          shift_d = {shift_q[23:0], 8'h00};
          if (cnt_q == 2'd3) begin
            cnt_d = '0;
            if (idx_q == LastIdx) begin
              state_d = StHalt;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = StDumpSel;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = StHalt;
    endcase
  end

  assign tx_data = shift_q[31:24];
  assign busy    = (state_q != StHalt);

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer: reset values, step, run/halt, unknown
// commands, full dumps with steady and random tx_ready, and reset mid-dump.
module tb_debug_sequencer;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_data;
  logic        prog_end;
  logic [31:0] reg_data;
  logic        tx_ready, tx_valid;
  logic [7:0]  tx_data;
  logic        stop_debug, debug_on, busy;
  logic [4:0]  debug_read_reg;

  int checks   = 0;
  int failures = 0;
  logic [7:0] got [0:255];

  debug_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_data       (cmd_data),
    .cmd_ready      (cmd_ready),
    .prog_end       (prog_end),
    .reg_data       (reg_data),
    .tx_ready       (tx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .stop_debug     (stop_debug),
    .debug_on       (debug_on),
    .debug_read_reg (debug_read_reg),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reg k holds 0A0B0C00+k, one cycle read latency
  always @(posedge clk) reg_data <= 32'h0A0B0C00 + {27'd0, debug_read_reg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the next one
  task automatic send(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Collects dump bytes until busy drops, or until stop_after bytes are taken
  task automatic do_dump(input bit rnd, input int stop_after, output int nb,
                         output int cyc, output int dbad, output int sbad);
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    nb = 0; cyc = 0; dbad = 0; sbad = 0;
    while (busy && cyc < 4000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!debug_on) dbad++;
      if (prev_stall && tx_data !== prev_data) sbad++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      cyc++;
      if (tx_valid && tx_ready) begin
        if (nb < 256) got[nb] = tx_data;
        nb++;
        if (nb == stop_after) begin
          @(posedge clk);
          #1;
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  function automatic int stream_errs(input int n);
    int         e = 0;
    logic [31:0] w;
    logic [7:0]  x;
    for (int i = 0; i < n; i++) begin
      w = 32'h0A0B0C00 + 32'(i / 4);
      x = 8'(w >> (24 - 8 * (i % 4)));
      if (got[i] !== x) e++;
    end
    return e;
  endfunction

  initial begin
    int low, nb, cyc, dbad, sbad, leak;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; prog_end = 1'b0; tx_ready = 1'b0;
    #12;
    chk("rst_stop_debug", stop_debug, 1);
    chk("rst_debug_on", debug_on, 0);
    chk("rst_read_reg", debug_read_reg, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);

    // Step accepted on the first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    send(8'h73);
    chk("step_stop_low", stop_debug, 0);
    chk("step_busy", busy, 1);
    chk("step_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("step_back_stop", stop_debug, 1);
    chk("step_back_busy", busy, 0);

    // Step with prog_end high still runs one cycle
    prog_end = 1'b1;
    send(8'h73);
    chk("step_pe_stop_low", stop_debug, 0);
    @(negedge clk);
    chk("step_pe_stop_high", stop_debug, 1);
    chk("step_pe_busy", busy, 0);
    prog_end = 1'b0;

    // Unknown byte in HALT
    cmd_valid = 1'b1; cmd_data = 8'h7A;
    chk("halt_unknown_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("halt_unknown_busy", busy, 0);
    chk("halt_unknown_stop", stop_debug, 1);

    // Run for 10 cycles, unknown byte mid-run, then prog_end
    send(8'h63);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      if (!stop_debug) low++;
      if (i == 3) begin
        cmd_valid = 1'b1; cmd_data = 8'h7A;
        chk("run_unknown_ready", cmd_ready, 1);
      end
      if (i == 4) cmd_valid = 1'b0;
      if (i == 9) prog_end = 1'b1;
      @(negedge clk);
    end
    prog_end = 1'b0;
    chk("run_low_cycles", low, 10);
    chk("run_end_busy", busy, 0);
    chk("run_end_stop", stop_debug, 1);

    // CMD_HALT together with prog_end: single transition, stays halted
    send(8'h63);
    chk("run2_busy", busy, 1);
    cmd_valid = 1'b1; cmd_data = 8'h68; prog_end = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; prog_end = 1'b0;
    chk("halt_both_busy", busy, 0);
    @(negedge clk);
    chk("halt_both_stay", busy, 0);
    chk("halt_both_ready", cmd_ready, 1);

    // CMD_HALT alone
    send(8'h63);
    cmd_valid = 1'b1; cmd_data = 8'h68;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("halt_cmd_busy", busy, 0);

    // Full dump, tx_ready held high
    send(8'h64);
    do_dump(1'b0, 0, nb, cyc, dbad, sbad);
    chk("dump_bytes", nb, 128);
    chk("dump_cycles", cyc, 192);
    chk("dump_debug_on", dbad, 0);
    chk("dump_stream", stream_errs(128), 0);
    chk("dump_end_busy", busy, 0);
    chk("dump_end_tx_valid", tx_valid, 0);

    // Full dump, random tx_ready
    send(8'h64);
    do_dump(1'b1, 0, nb, cyc, dbad, sbad);
    chk("rnd_bytes", nb, 128);
    chk("rnd_no_timeout", (cyc < 4000) ? 1 : 0, 1);
    chk("rnd_debug_on", dbad, 0);
    chk("rnd_stall_stable", sbad, 0);
    chk("rnd_stream", stream_errs(128), 0);

    // Reset after 50 bytes aborts the dump
    send(8'h64);
    do_dump(1'b0, 50, nb, cyc, dbad, sbad);
    chk("abort_bytes", nb, 50);
    rst = 1'b1;
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_debug_on", debug_on, 0);
    chk("abort_tx_data", tx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    leak = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || busy) leak++;
    end
    chk("abort_no_leak", leak, 0);
    send(8'h64);
    do_dump(1'b0, 0, nb, cyc, dbad, sbad);
    chk("restart_bytes", nb, 128);
    chk("restart_cycles", cyc, 192);
    chk("restart_stream", stream_errs(128), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
